aes_key_expander: RTL
=====================

# aes_key_expander

Iterative, parametrised AES key expander: accepts a 128-, 192- or 256-bit cipher key and produces one 32-bit expanded-key word per clock into an internal round-key store. The 128-bit round keys are served through a random-access read port. It replaces the fully unrolled AES-128 schedule with a single shared word datapath (RotWord, four `sub_box` instances, Rcon). It sits beside the round datapath, which reads round key `r` by index.

## Interface
Parameters:
- `KEY_BITS`, default 128, cipher key length. Legal values are 128, 192 and 256; any other value is an elaboration error.
- Derived, not overridable: `NK` = KEY_BITS/32 (4/6/8), `NR` = NK+6 (10/12/14), `NW` = 4·(NR+1) (44/52/60).

Ports (MSB-first `[0:N-1]` vectors; byte 0 at bits `[0:7]`):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a new expansion of `key_in`.
- `key_in` in KEY_BITS: cipher key; word j is `key_in[32j:32j+31]`. Sampled only on the accepting edge.
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle pulse when the last word has been written.
- `keys_valid` out 1: store holds a complete schedule for the last accepted key.
- `rk_idx` in 4: round-key index, 0..NR.
- `rk_data` out 128: round key `rk_idx` = words 4·rk_idx .. 4·rk_idx+3, concatenated with the lowest word first. Combinational read.

## Operation
- Store: NW × 32-bit word array, no reset on contents. 6-bit word counter `i`. Rcon register holding 01,02,04,08,10,20,40,80,1B,36 (advanced by xtime).
- States: IDLE, EXPAND.
- IDLE, start=1: write `w[0..NK-1]` from `key_in`. Then set i=NK, Rcon=01, busy=1, keys_valid=0, and go to EXPAND.
- EXPAND, each cycle:
  - `t = w[i-1]`.
  - If `i mod NK == 0`: `t = SubWord(RotWord(t)) ^ {Rcon,24'h0}`, and Rcon advances after use.
  - Else if `NK == 8` and `i mod 8 == 4`: `t = SubWord(t)`.
  - Write `w[i] = w[i-NK] ^ t`, then `i++`.
  - `i mod NK` is tracked with a separate wrap counter, not a divider.
- Exit on the edge that writes `w[NW-1]`: busy=0, done=1 for the next cycle only, keys_valid=1, go to IDLE.
- `start` while in EXPAND is ignored. There is no queueing, and `key_in` is not re-sampled.
- `start` in the cycle `done` is high is accepted normally, since the state is IDLE. keys_valid drops to 0 on that same edge.
- `rk_data`:
  - Returns 0 when keys_valid=0.
  - Returns 0 when `rk_idx > NR`.
  - Otherwise returns store contents.
- Reset asserted mid-expansion: abort immediately, state=IDLE, store contents become don't-care, keys_valid=0.

## Timing
- Reset values: busy=0, done=0, keys_valid=0, rk_data=0, state IDLE, i=0, Rcon=01.
- Accept edge E0: key words written; busy is high from E0.
- Words NK..NW-1 are written on edges E1..E(NW-NK).
- Edge E(NW-NK) (E40/E46/E52 for 128/192/256): busy falls, done rises, keys_valid rises. done falls at the following edge.
- Total start-to-done latency is NW-NK cycles: 40, 46, 52.
- rk_data is valid in the same cycle as a valid rk_idx once keys_valid=1. Zero-cycle read, no pipeline.
- Critical path is w[i-1] → RotWord → sub_box → XOR Rcon → XOR w[i-NK] → store write. No multicycle paths.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse → done exactly 40 cycles after the accept edge; rk_idx=1 → a0fafe1788542cb123a339392a6c7605; rk_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=0 → the key; rk_idx=11 → 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 46 cycles; rk_idx=12 → e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 52 cycles; rk_idx=14 → fe4890d1e6188d0b046df344706c631e. This exercises the `i mod 8 == 4` SubWord path.
- AES-128:
  - Pulse start with key A, then hold start high with key B through EXPAND → key B is ignored; the result matches key A and done pulses exactly once.
  - Re-start with key B in the done cycle → keys_valid=0 for 40 cycles, then key B's schedule is served.
- Assert rst at cycle 20 of an expansion → busy=0, done=0, keys_valid=0, rk_data=0 immediately and asynchronously. A fresh start afterwards yields the correct full schedule after 40 cycles.
- Reset release followed by start in the first clock cycle → the start is accepted; check Rcon restarts at 01 by comparing round key 1 against the vector above.

Source files
------------

// File: rtl/aes_key_expander.sv
// Iterative AES key expander (128/192/256-bit keys): one expanded word per clock
// into a round-key store, served as 128-bit round keys through a combinational read port.

module sub_box (
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [7:0] sq;
  logic [7:0] inv;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [0:KEY_BITS-1] key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [3:0]          rk_idx,
  output logic [0:127]        rk_data
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [2:0] WRAP_MAX = 3'(NK - 1);
  localparam logic [3:0] NR_W     = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state, state_nx;
  logic [5:0]  i, i_nx;
  logic [2:0]  wrap, wrap_nx;
  logic [7:0]  rcon, rcon_nx;
  logic        done_nx, valid_nx;

  logic [31:0] w [0:NW-1];
  logic [31:0] w_prev, w_back, rot, sub_in, sub_out, t, w_new;
  logic [5:0]  rk_base;

  assign w_prev = w[i - 6'd1];
  assign w_back = w[i - NK_W];
  assign rot    = {w_prev[23:0], w_prev[31:24]};
  assign sub_in = (wrap == 3'd0) ? rot : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sub_box u_sub_box (
      .a (sub_in[8*b +: 8]),
      .s (sub_out[8*b +: 8])
    );
  end

  // wrap tracks i mod NK without a divider
  always_comb begin
    t = w_prev;
    if (wrap == 3'd0)
      t = sub_out ^ {rcon, 24'h000000};
    else if (NK == 8 && wrap == 3'd4)
      t = sub_out;
    w_new = w_back ^ t;
  end

  // Store contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int j = 0; j < NK; j++)
        w[j] <= key_in[32*j +: 32];
    end else if (state == EXPAND) begin
      w[i] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      i          <= 6'd0;
      wrap       <= 3'd0;
      rcon       <= 8'h01;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      i          <= i_nx;
      wrap       <= wrap_nx;
      rcon       <= rcon_nx;
      done       <= done_nx;
      keys_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    i_nx     = i;
    wrap_nx  = wrap;
    rcon_nx  = rcon;
    done_nx  = 1'b0;
    valid_nx = keys_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = EXPAND;
          i_nx     = NK_W;
          wrap_nx  = 3'd0;
          rcon_nx  = 8'h01;
          valid_nx = 1'b0;
        end
      end
      EXPAND: begin
        if (wrap == 3'd0)
          rcon_nx = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (i == LAST_W) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          valid_nx = 1'b1;
        end else begin
          i_nx    = i + 6'd1;
          wrap_nx = (wrap == WRAP_MAX) ? 3'd0 : wrap + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy    = (state == EXPAND);
  assign rk_base = {rk_idx, 2'b00};

  always_comb begin
    rk_data = '0;
    if (keys_valid && rk_idx <= NR_W)
      rk_data = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
  end
endmodule
